// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI types, limits and width clamping helper
//
// Purpose: definitions shared by spi_tx and spi_rx.
//   SPI_MAX_WIDTH  : widest word either side can handle
//   spi_mode_t     : CPOL/CPHA mode encoding
//   spi_rx_state_t : receive FSM states
//   clamp_width    : maps a requested word width onto 1..max_w
package spi_pkg;

  localparam int SPI_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    MODE0,
    MODE1,
    MODE2,
    MODE3
  } spi_mode_t;

  typedef enum logic {
    RX_IDLE,
    RX_SHIFT
  } spi_rx_state_t;

  // Out-of-range requests (0 or wider than max_w) fall back to max_w.
  // The result is 6 bits, so a width of 64 comes back as 0; callers
  // decode 0 as 64.
  function automatic logic [5:0] clamp_width(input logic [5:0] w,
                                             input logic [6:0] max_w);
    if (w == 6'd0 || {1'b0, w} > max_w) begin
      return max_w[5:0];
    end
    return w;
  endfunction

endpackage

// File: rtl/spi_rx_out_reg.sv
// rtl/spi_rx_out_reg.sv - single-entry AXI-Stream output register with overflow detect
//
// Purpose: holds one completed word for the downstream consumer and flags
// words that arrive while the register is still full.
// Ports:
//   phased_sclk  : clock
//   rst          : synchronous active-high reset
//   load_i       : a word completes on this edge
//   data_i       : completed word
//   clr_i        : clears the overflow flag
//   tready_i     : downstream accept
//   tdata_o      : held word
//   tvalid_o     : word available
//   overflow_o   : sticky, a word was dropped
module spi_rx_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  phased_sclk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  clr_i,
  input  logic                  tready_i,
  output logic [DATA_WIDTH-1:0] tdata_o,
  output logic                  tvalid_o,
  output logic                  overflow_o
);

  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q;
  logic                  overflow_q;
  logic                  can_load;

  // The register frees up on the handshake edge itself, so a word that
  // completes on that edge can replace the one being accepted.
  assign can_load = ~tvalid_q | tready_i;

  always_ff @(posedge phased_sclk) begin
    if (rst) begin
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (load_i && can_load) begin
        tdata_q  <= data_i;
        tvalid_q <= 1'b1;
      end else if (tvalid_q && tready_i) begin
        tvalid_q <= 1'b0;
      end

      // Set has priority over clear.
      if (load_i && !can_load) begin
        overflow_q <= 1'b1;
      end else if (clr_i) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign tdata_o    = tdata_q;
  assign tvalid_o   = tvalid_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/spi_rx.sv
// rtl/spi_rx.sv - SPI receive deserializer with AXI-Stream master output
//
// Purpose: samples rxd MSB-first on each phased_sclk rising edge, assembles
// words of a run-time width and hands them to an AXI-Stream output register.
// Ports:
//   phased_sclk     : sampling clock (mode already applied upstream)
//   rst             : synchronous active-high reset
//   rxd             : serial data in
//   rx_enable       : frame active; low aborts a word in progress
//   spi_word_width  : bits per word, latched on the first bit of each word
//   m_axis_tdata    : received word, right-aligned, zero-extended
//   m_axis_tvalid   : word available
//   m_axis_tready   : downstream accept
//   overflow_clr    : clears overflow and frame_err
//   busy            : a word is being shifted in
//   overflow        : sticky, a completed word was dropped
//   frame_err       : sticky, rx_enable fell mid-word
module spi_rx
  import spi_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 8
) (
  input  logic                       phased_sclk,
  input  logic                       rst,
  input  logic                       rxd,
  input  logic                       rx_enable,
  input  logic [5:0]                 spi_word_width,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  input  logic                       overflow_clr,
  output logic                       busy,
  output logic                       overflow,
  output logic                       frame_err
);

  localparam logic [6:0] MAX_W = 7'(AXIS_DATA_WIDTH);

  spi_rx_state_t               state_q;
  logic [6:0]                  bit_cnt_q;
  logic [6:0]                  width_q;
  logic [AXIS_DATA_WIDTH-1:0]  shift_q;
  logic                        frame_err_q;

  logic [5:0]                  width_clamped;
  logic [6:0]                  width_new;
  logic [6:0]                  width_eff;
  logic [AXIS_DATA_WIDTH-1:0]  shift_d;
  logic [AXIS_DATA_WIDTH-1:0]  word_mask;
  logic [AXIS_DATA_WIDTH-1:0]  word_data;
  logic                        word_done;

  always_comb begin
    width_clamped = clamp_width(spi_word_width, MAX_W);
    // clamp_width returns 0 to mean a 64-bit word.
    width_new = (width_clamped == 6'd0) ? 7'd64 : {1'b0, width_clamped};
    // On the first bit the freshly sampled width applies; afterwards the
    // latched one does.
    width_eff = (state_q == RX_IDLE) ? width_new : width_q;

    shift_d    = shift_q << 1;
    shift_d[0] = rxd;

    // The shift register keeps stale bits from earlier words above the
    // current width; the mask zero-extends the result.
    word_mask = '0;
    for (int i = 0; i < AXIS_DATA_WIDTH; i++) begin
      word_mask[i] = (7'(i) < width_eff);
    end
    word_data = shift_d & word_mask;

    word_done = 1'b0;
    if (rx_enable) begin
      if (state_q == RX_IDLE) begin
        word_done = (width_new == 7'd1);
      end else begin
        word_done = (bit_cnt_q == width_q - 7'd1);
      end
    end
  end

  always_ff @(posedge phased_sclk) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      bit_cnt_q   <= '0;
      width_q     <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      case (state_q)
        RX_IDLE: begin
          if (rx_enable) begin
            width_q <= width_new;
            shift_q <= shift_d;
            if (width_new == 7'd1) begin
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= 7'd1;
              state_q   <= RX_SHIFT;
            end
          end
        end
        RX_SHIFT: begin
          if (rx_enable) begin
            shift_q <= shift_d;
            if (word_done) begin
              bit_cnt_q <= '0;
              state_q   <= RX_IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 7'd1;
            end
          end else begin
            bit_cnt_q <= '0;
            state_q   <= RX_IDLE;
          end
        end
        default: begin
          bit_cnt_q <= '0;
          state_q   <= RX_IDLE;
        end
      endcase

      // Set has priority over clear.
      if (state_q == RX_SHIFT && !rx_enable) begin
        frame_err_q <= 1'b1;
      end else if (overflow_clr) begin
        frame_err_q <= 1'b0;
      end
    end
  end

  spi_rx_out_reg #(
    .DATA_WIDTH(AXIS_DATA_WIDTH)
  ) u_out_reg (
    .phased_sclk(phased_sclk),
    .rst        (rst),
    .load_i     (word_done),
    .data_i     (word_data),
    .clr_i      (overflow_clr),
    .tready_i   (m_axis_tready),
    .tdata_o    (m_axis_tdata),
    .tvalid_o   (m_axis_tvalid),
    .overflow_o (overflow)
  );

  assign busy      = (state_q == RX_SHIFT);
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_rx.sv
// tb/tb_spi_rx.sv - directed self-checking bench for spi_rx
module tb_spi_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b0;
  logic       rx_enable = 1'b0;
  logic [5:0] spi_word_width = 6'd8;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic       overflow_clr = 1'b0;
  logic       busy;
  logic       overflow;
  logic       frame_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_rx #(
    .AXIS_DATA_WIDTH(8)
  ) dut (
    .phased_sclk   (clk),
    .rst           (rst),
    .rxd           (rxd),
    .rx_enable     (rx_enable),
    .spi_word_width(spi_word_width),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .overflow_clr  (overflow_clr),
    .busy          (busy),
    .overflow      (overflow),
    .frame_err     (frame_err)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic       rxd;
    logic [5:0] ww;
    logic       rdy;
    logic       clr;
    logic       vld;
    logic [7:0] data;
    logic       busy;
    logic       ovf;
    logic       ferr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask

  task automatic v(input string n, input logic r, input logic e, input logic d,
                   input logic [5:0] w, input logic rd, input logic c,
                   input logic ev, input logic [7:0] ed, input logic eb,
                   input logic eo, input logic ef);
    vec_t x;
    x.name = n; x.rst = r; x.en = e; x.rxd = d; x.ww = w; x.rdy = rd; x.clr = c;
    x.vld = ev; x.data = ed; x.busy = eb; x.ovf = eo; x.ferr = ef;
    vecs.push_back(x);
  endtask

  // Pushes cnt bits of val starting at bit hi going down; all are mid-word
  // bits, so busy is expected high and the other outputs constant.
  task automatic mid(input string n, input logic [5:0] w, input logic rd,
                     input logic [7:0] val, input int hi, input int cnt,
                     input logic ev, input logic [7:0] ed, input logic eo,
                     input logic ef);
    for (int k = 0; k < cnt; k++) begin
      v($sformatf("%s_b%0d", n, k + 1), 0, 1, val[hi-k], w, rd, 0, ev, ed, 1, eo, ef);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic d,
                       input logic [5:0] w, input logic rd, input logic c);
    rst = r; rx_enable = e; rxd = d; spi_word_width = w; m_axis_tready = rd;
    overflow_clr = c;
    tick();
  endtask

  task automatic send(input logic [5:0] w, input logic rd, input logic [7:0] val,
                      input int hi, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      drive(0, 1, val[hi-k], w, rd, 0);
    end
  endtask

  initial begin
    // reset
    v("reset", 1, 0, 0, 8, 1, 0, 0, 8'h00, 0, 0, 0);
    // 0xA5, W=8
    mid("a5", 8, 1, 8'hA5, 7, 7, 0, 8'h00, 0, 0);
    v("a5_done", 0, 1, 1, 8, 1, 0, 1, 8'hA5, 0, 0, 0);
    v("a5_drop", 0, 0, 0, 8, 1, 0, 0, 8'hA5, 0, 0, 0);
    // W=5 -> 0x16, then width 0 -> W=8 word 0x81 back to back
    mid("w5", 5, 1, 8'h16, 4, 4, 0, 8'hA5, 0, 0);
    v("w5_done", 0, 1, 0, 5, 1, 0, 1, 8'h16, 0, 0, 0);
    mid("w0", 0, 1, 8'h81, 7, 7, 0, 8'h16, 0, 0);
    v("w0_done", 0, 1, 1, 0, 1, 0, 1, 8'h81, 0, 0, 0);
    v("w0_drop", 0, 0, 0, 0, 1, 0, 0, 8'h81, 0, 0, 0);
    // W=1: each bit is a word; handshake and reload on the same edge
    v("w1_a", 0, 1, 1, 1, 1, 0, 1, 8'h01, 0, 0, 0);
    v("w1_b", 0, 1, 0, 1, 1, 0, 1, 8'h00, 0, 0, 0);
    v("w1_drop", 0, 0, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0);
    // width 20 clamps to 8; changing the input to 3 mid-word has no effect
    v("wbig_b1", 0, 1, 1, 20, 1, 0, 0, 8'h00, 1, 0, 0);
    mid("wbig", 3, 1, 8'h96, 6, 6, 0, 8'h00, 0, 0);
    v("wbig_done", 0, 1, 0, 3, 1, 0, 1, 8'h96, 0, 0, 0);
    v("wbig_drop", 0, 0, 0, 3, 1, 0, 0, 8'h96, 0, 0, 0);
    // back-to-back 0x3C, 0xC3 with tready high
    mid("b2b_a", 8, 1, 8'h3C, 7, 7, 0, 8'h96, 0, 0);
    v("b2b_a_done", 0, 1, 0, 8, 1, 0, 1, 8'h3C, 0, 0, 0);
    mid("b2b_b", 8, 1, 8'hC3, 7, 7, 0, 8'h3C, 0, 0);
    v("b2b_b_done", 0, 1, 1, 8, 1, 0, 1, 8'hC3, 0, 0, 0);
    v("b2b_drop", 0, 0, 0, 8, 1, 0, 0, 8'hC3, 0, 0, 0);
    // tready low: 0x11 held, 0x22 dropped with overflow
    mid("ovf_a", 8, 0, 8'h11, 7, 7, 0, 8'hC3, 0, 0);
    v("ovf_a_done", 0, 1, 1, 8, 0, 0, 1, 8'h11, 0, 0, 0);
    mid("ovf_b", 8, 0, 8'h22, 7, 7, 1, 8'h11, 0, 0);
    v("ovf_b_done", 0, 1, 0, 8, 0, 0, 1, 8'h11, 0, 1, 0);
    v("ovf_hold", 0, 0, 0, 8, 0, 0, 1, 8'h11, 0, 1, 0);
    v("ovf_clr", 0, 0, 0, 8, 1, 1, 0, 8'h11, 0, 0, 0);
    // abort after 3 bits; clear on the abort edge loses to the set
    mid("abort", 8, 1, 8'hC0, 7, 3, 0, 8'h11, 0, 0);
    v("abort_edge", 0, 0, 0, 8, 1, 1, 0, 8'h11, 0, 0, 1);
    mid("post", 8, 1, 8'h5A, 7, 7, 0, 8'h11, 0, 1);
    v("post_done", 0, 1, 0, 8, 1, 0, 1, 8'h5A, 0, 0, 1);
    v("ferr_clr", 0, 0, 0, 8, 1, 1, 0, 8'h5A, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].rxd, vecs[i].ww, vecs[i].rdy, vecs[i].clr);
      chk({vecs[i].name, "_tvalid"}, 64'(m_axis_tvalid), 64'(vecs[i].vld));
      chk({vecs[i].name, "_tdata"}, 64'(m_axis_tdata), 64'(vecs[i].data));
      chk({vecs[i].name, "_busy"}, 64'(busy), 64'(vecs[i].busy));
      chk({vecs[i].name, "_overflow"}, 64'(overflow), 64'(vecs[i].ovf));
      chk({vecs[i].name, "_frame_err"}, 64'(frame_err), 64'(vecs[i].ferr));
    end

    // Reset mid-word with every flag and the output register populated.
    send(8, 0, 8'hC0, 7, 2);
    drive(0, 0, 0, 8, 0, 0);
    chk("rst_pre_ferr", 64'(frame_err), 64'd1);
    send(8, 0, 8'h0F, 7, 8);
    chk("rst_pre_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("rst_pre_tdata", 64'(m_axis_tdata), 64'h0F);
    send(1, 0, 8'h01, 0, 1);
    chk("rst_pre_ovf", 64'(overflow), 64'd1);
    send(6, 0, 8'hFF, 7, 4);
    chk("rst_pre_busy", 64'(busy), 64'd1);
    drive(1, 1, 1, 6, 0, 0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'h00);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_ferr", 64'(frame_err), 64'd0);
    send(8, 1, 8'hFF, 7, 7);
    chk("rst_ff_busy", 64'(busy), 64'd1);
    chk("rst_ff_tvalid_early", 64'(m_axis_tvalid), 64'd0);
    send(8, 1, 8'hFF, 0, 1);
    chk("rst_ff_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("rst_ff_tdata", 64'(m_axis_tdata), 64'hFF);
    chk("rst_ff_busy_done", 64'(busy), 64'd0);
    drive(0, 0, 0, 8, 1, 0);
    chk("rst_ff_drop", 64'(m_axis_tvalid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
